// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions for the fetch sequencer: state encoding and
// default address map.
package pc_sequencer_pkg;

    localparam int unsigned PC_WIDTH_DEF   = 32;
    localparam int unsigned RESET_ADDR_DEF = 0;
    localparam int unsigned INT_ADDR_DEF   = 32;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_INT_PC,
        ST_INT_FLAGS,
        ST_INT_JUMP
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_int_edge_latch.sv
// Rising-edge detector on the interrupt request with a sticky pending flag.
module int_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic int_req,
    input  logic clr,
    output logic pending
);

    logic int_req_d;

    // Previous-value register resets high so a request already asserted at
    // reset release is not mistaken for an edge. A fresh edge wins over clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_d <= 1'b1;
            pending   <= 1'b0;
        end else begin
            int_req_d <= int_req;
            if (int_req && !int_req_d) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential/two-word advance, branch and return
// redirects, and a four-cycle interrupt entry that pushes pc and flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]   RESET_ADDR = PC_WIDTH'(RESET_ADDR_DEF),
    parameter logic [PC_WIDTH-1:0]   INT_ADDR   = PC_WIDTH'(INT_ADDR_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                int_req,
    input  logic                stall,
    input  logic                two_word,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                ret_valid,
    input  logic [PC_WIDTH-1:0] ret_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_en,
    output logic                flush,
    output logic                push_pc,
    output logic                push_flags,
    output logic [PC_WIDTH-1:0] push_data,
    output logic                int_ack
);

    seq_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] saved_pc_q, saved_pc_d;
    logic                jumped_q, jumped_d;
    logic                int_pending;

    int_edge_latch u_int_edge_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .int_req (int_req),
        .clr     (int_ack),
        .pending (int_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_ADDR;
            saved_pc_q <= '0;
            jumped_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            saved_pc_q <= saved_pc_d;
            jumped_q   <= jumped_d;
        end
    end

    // jumped_q blocks a back-to-back interrupt until the handler fetches once.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        saved_pc_d = saved_pc_q;
        jumped_d   = jumped_q;
        fetch_en   = 1'b0;
        flush      = 1'b0;
        push_pc    = 1'b0;
        push_flags = 1'b0;
        int_ack    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_en = !stall;
                if (!stall) jumped_d = 1'b0;
                if (ret_valid) begin
                    pc_d  = ret_pc;
                    flush = 1'b1;
                end else if (branch_taken) begin
                    pc_d  = branch_target;
                    flush = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (int_pending && !jumped_q) begin
                    fetch_en   = 1'b0;
                    flush      = 1'b1;
                    saved_pc_d = pc_q;
                    state_d    = ST_INT_PC;
                end else begin
                    pc_d = two_word ? pc_q + PC_WIDTH'(2) : pc_q + PC_WIDTH'(1);
                end
            end
            ST_INT_PC: begin
                push_pc = 1'b1;
                if (!stall) state_d = ST_INT_FLAGS;
            end
            ST_INT_FLAGS: begin
                push_flags = 1'b1;
                if (!stall) begin
                    state_d = ST_INT_JUMP;
                    pc_d    = INT_ADDR;
                end
            end
            ST_INT_JUMP: begin
                int_ack = 1'b1;
                if (!stall) begin
                    state_d  = ST_RUN;
                    jumped_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc        = pc_q;
    assign push_data = (state_q == ST_INT_PC) ? saved_pc_q : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: directed cases plus a randomized run
// against a cycle-level reference model of the fetch sequencing rules.
module tb_pc_sequencer;

    localparam logic [31:0] INT_A = 32'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_req = 1'b0;
    logic        stall = 1'b0;
    logic        two_word = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] pc;
    logic        fetch_en, flush, push_pc, push_flags, int_ack;
    logic [31:0] push_data;
    wire  [4:0]  ctl = {fetch_en, flush, push_pc, push_flags, int_ack};

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .stall(stall),
        .two_word(two_word), .branch_taken(branch_taken),
        .branch_target(branch_target), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .pc(pc), .fetch_en(fetch_en), .flush(flush), .push_pc(push_pc),
        .push_flags(push_flags), .push_data(push_data), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        stall = 0; two_word = 0; branch_taken = 0; ret_valid = 0;
        branch_target = '0; ret_pc = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clr_inputs();
        int_req = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 0;
        #12;
        n_checks++;
        if (pc !== 32'h0 || ctl !== 5'b0 || push_data !== 32'h0)
            $display("FAIL reset_hold: pc=%h ctl=%b data=%h want 0/00000/0", pc, ctl, push_data);
        else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1;
        #1;
        n_checks++;
        if (pc !== 32'h0 || ctl !== 5'b0)
            $display("FAIL boot_cycle: pc=%h ctl=%b want 0/00000", pc, ctl);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        n_checks++;
        if (ctl !== 5'b0) $display("FAIL seq_boot: ctl=%b want 00000", ctl);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pc !== 32'(i) || ctl !== 5'b10000)
                $display("FAIL seq_fetch: pc=%h ctl=%b want %h/10000", pc, ctl, i);
            else n_pass++;
        end
    endtask

    task automatic test_two_word();
        do_reset();
        tick();
        repeat (5) tick();
        two_word = 1;
        #1;
        n_checks++;
        if (pc !== 32'h5 || ctl !== 5'b10000)
            $display("FAIL tw_at5: pc=%h ctl=%b want 5/10000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h7) $display("FAIL tw_plus2: pc=%h want 7", pc);
        else n_pass++;
        ret_valid = 1; ret_pc = 32'hFFFF_FFFF;
        tick();
        ret_valid = 0;
        #1;
        n_checks++;
        if (pc !== 32'hFFFF_FFFF) $display("FAIL tw_load_max: pc=%h want ffffffff", pc);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h1) $display("FAIL tw_wrap2: pc=%h want 1", pc);
        else n_pass++;
        two_word = 0; ret_valid = 1; ret_pc = 32'hFFFF_FFFF;
        tick();
        ret_valid = 0;
        #1;
        tick();
        n_checks++;
        if (pc !== 32'h0) $display("FAIL tw_wrap1: pc=%h want 0", pc);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        tick();
        branch_taken = 1; branch_target = 32'h40;
        ret_valid = 1; ret_pc = 32'h80;
        #1;
        n_checks++;
        if (ctl !== 5'b11000) $display("FAIL redir_flush: ctl=%b want 11000", ctl);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h80 || ctl !== 5'b10000)
            $display("FAIL redir_ret_wins: pc=%h ctl=%b want 80/10000", pc, ctl);
        else n_pass++;
        stall = 1;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) $display("FAIL stall_ctl: ctl=%b want 00000", ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h80) $display("FAIL stall_hold: pc=%h want 80", pc);
        else n_pass++;
        branch_taken = 1; branch_target = 32'h40;
        #1;
        n_checks++;
        if (ctl !== 5'b01000) $display("FAIL br_stall_ctl: ctl=%b want 01000", ctl);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h40 || ctl !== 5'b10000)
            $display("FAIL br_target: pc=%h ctl=%b want 40/10000", pc, ctl);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        do_reset();
        tick();
        repeat (15) tick();
        int_req = 1;
        #1;
        n_checks++;
        if (pc !== 32'h0F || ctl !== 5'b10000)
            $display("FAIL int_pre: pc=%h ctl=%b want 0f/10000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h10 || ctl !== 5'b01000)
            $display("FAIL int_accept: pc=%h ctl=%b want 10/01000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h10 || ctl !== 5'b00100 || push_data !== 32'h10)
            $display("FAIL int_push_pc: pc=%h ctl=%b data=%h want 10/00100/10", pc, ctl, push_data);
        else n_pass++;
        tick();
        n_checks++;
        if (ctl !== 5'b00010 || push_data !== 32'h0)
            $display("FAIL int_push_flags: ctl=%b data=%h want 00010/0", ctl, push_data);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== INT_A || ctl !== 5'b00001)
            $display("FAIL int_ack: pc=%h ctl=%b want 20/00001", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== INT_A || ctl !== 5'b10000)
            $display("FAIL int_fetch_vec: pc=%h ctl=%b want 20/10000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h21 || ctl !== 5'b10000)
            $display("FAIL int_no_repeat: pc=%h ctl=%b want 21/10000", pc, ctl);
        else n_pass++;
        int_req = 0;
    endtask

    task automatic test_int_stall();
        int lat;
        do_reset();
        tick(); tick(); tick();
        int_req = 1;
        tick();
        n_checks++;
        if (pc !== 32'h3 || ctl !== 5'b01000)
            $display("FAIL ist_accept: pc=%h ctl=%b want 3/01000", pc, ctl);
        else n_pass++;
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            lat++;
            stall = (k < 3);
            #1;
            n_checks++;
            if (ctl !== 5'b00100 || push_data !== 32'h3)
                $display("FAIL ist_push_hold%0d: ctl=%b data=%h want 00100/3", k, ctl, push_data);
            else n_pass++;
        end
        while (!(fetch_en === 1'b1 && pc === INT_A) && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 7) $display("FAIL ist_latency: got %0d cycles want 7", lat);
        else n_pass++;
        int_req = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        int_req = 1;
        tick();
        branch_taken = 1; branch_target = 32'h50;
        #1;
        n_checks++;
        if (pc !== 32'h1 || ctl !== 5'b11000)
            $display("FAIL b2b_redir_first: pc=%h ctl=%b want 1/11000", pc, ctl);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h50 || ctl !== 5'b01000)
            $display("FAIL b2b_accept: pc=%h ctl=%b want 50/01000", pc, ctl);
        else n_pass++;
        int_req = 0;
        tick();
        branch_taken = 1; branch_target = 32'h99; ret_valid = 1; ret_pc = 32'h77;
        #1;
        n_checks++;
        if (ctl !== 5'b00100 || push_data !== 32'h50)
            $display("FAIL b2b_saved_target: ctl=%b data=%h want 00100/50", ctl, push_data);
        else n_pass++;
        tick();
        clr_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h50 || ctl !== 5'b00010)
            $display("FAIL b2b_redir_ignored: pc=%h ctl=%b want 50/00010", pc, ctl);
        else n_pass++;
        tick();
        int_req = 1;
        #1;
        n_checks++;
        if (pc !== INT_A || ctl !== 5'b00001)
            $display("FAIL b2b_ack: pc=%h ctl=%b want 20/00001", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== INT_A || ctl !== 5'b10000)
            $display("FAIL b2b_fetch_first: pc=%h ctl=%b want 20/10000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h21 || ctl !== 5'b01000)
            $display("FAIL b2b_second_accept: pc=%h ctl=%b want 21/01000", pc, ctl);
        else n_pass++;
        tick();
        n_checks++;
        if (push_data !== 32'h21 || ctl !== 5'b00100)
            $display("FAIL b2b_second_push: ctl=%b data=%h want 00100/21", ctl, push_data);
        else n_pass++;
        int_req = 0;
    endtask

    task automatic test_reset_mid_int();
        do_reset();
        tick();
        int_req = 1;
        tick(); tick(); tick();
        n_checks++;
        if (ctl !== 5'b00010) $display("FAIL rmi_in_flags: ctl=%b want 00010", ctl);
        else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if (pc !== 32'h0 || ctl !== 5'b0 || push_data !== 32'h0)
            $display("FAIL rmi_async: pc=%h ctl=%b data=%h want 0/00000/0", pc, ctl, push_data);
        else n_pass++;
        #1;
        rst_n = 1;
        #1;
        n_checks++;
        if (pc !== 32'h0 || ctl !== 5'b0)
            $display("FAIL rmi_boot: pc=%h ctl=%b want 0/00000", pc, ctl);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pc !== 32'(i) || ctl !== 5'b10000)
                $display("FAIL rmi_restart: pc=%h ctl=%b want %h/10000", pc, ctl, i);
            else n_pass++;
        end
        int_req = 0;
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_saved, e_data;
        logic [4:0]  e_ctl;
        bit          m_boot, m_pend, m_prev, m_need, edge_ev, ack_ev;
        int          m_phase;
        do_reset();
        m_pc = 32'h0; m_saved = 32'h0; m_boot = 1; m_pend = 0; m_prev = 1;
        m_need = 0; m_phase = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            stall         = ($urandom_range(0, 3) == 0);
            two_word      = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            ret_valid     = ($urandom_range(0, 9) == 0);
            branch_target = $urandom;
            ret_pc        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 7) == 0) int_req = ~int_req;
            #1;
            e_ctl = 5'b0;
            e_data = 32'h0;
            if (!m_boot) begin
                case (m_phase)
                    0: begin
                        if (ret_valid || branch_taken) e_ctl = {!stall, 1'b1, 3'b000};
                        else if (stall)                e_ctl = 5'b00000;
                        else if (m_pend && !m_need)    e_ctl = 5'b01000;
                        else                           e_ctl = 5'b10000;
                    end
                    1: begin e_ctl = 5'b00100; e_data = m_saved; end
                    2: e_ctl = 5'b00010;
                    default: e_ctl = 5'b00001;
                endcase
            end
            n_checks++;
            if (pc !== m_pc || ctl !== e_ctl || push_data !== e_data)
                $display("FAIL rand_cyc%0d: pc=%h ctl=%b data=%h want %h/%b/%h",
                         cyc, pc, ctl, push_data, m_pc, e_ctl, e_data);
            else n_pass++;
            edge_ev = int_req && !m_prev;
            ack_ev  = !m_boot && (m_phase == 3);
            if (m_boot) begin
                m_boot = 0;
            end else if (m_phase == 0) begin
                if (ret_valid)                m_pc = ret_pc;
                else if (branch_taken)        m_pc = branch_target;
                else if (stall)               m_pc = m_pc;
                else if (m_pend && !m_need) begin m_saved = m_pc; m_phase = 1; end
                else                          m_pc = m_pc + (two_word ? 32'd2 : 32'd1);
                if (!stall) m_need = 0;
            end else if (!stall) begin
                if (m_phase == 1)      m_phase = 2;
                else if (m_phase == 2) begin m_phase = 3; m_pc = INT_A; end
                else                   begin m_phase = 0; m_need = 1; end
            end
            m_pend = edge_ev ? 1'b1 : (ack_ev ? 1'b0 : m_pend);
            m_prev = int_req;
            tick();
        end
        clr_inputs();
        int_req = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_two_word();
        test_redirect();
        test_interrupt();
        test_int_stall();
        test_back_to_back();
        test_reset_mid_int();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of pc, targets and pushed return address.
REQ-002 Parameter RESET_ADDR, default 0: fetch address after reset.
REQ-003 Parameter INT_ADDR, default 32: interrupt service entry address.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port int_req, input, 1: external interrupt request; its rising edge is the event.
REQ-007 Port stall, input, 1: hazard hold from the pipeline; pc and state are frozen.
REQ-008 Port two_word, input, 1: fetched instruction carries an immediate word; advance pc by 2.
REQ-009 Port branch_taken, input, 1, and branch_target, input, PC_WIDTH: JZ/JN/JC/JMP/CALL redirect.
REQ-010 Port ret_valid, input, 1, and ret_pc, input, PC_WIDTH: RET/RTI popped return address.
REQ-011 Port pc, output, PC_WIDTH: current fetch address to instruction memory.
REQ-012 Port fetch_en, output, 1: instruction memory read valid this cycle.
REQ-013 Port flush, output, 1: squash younger in-flight instructions.
REQ-014 Ports push_pc and push_flags, output, 1 each: request to memory stage to push to stack.
REQ-015 Port push_data, output, PC_WIDTH: saved return address while push_pc=1, else 0.
REQ-016 Port int_ack, output, 1: one-cycle pulse when the interrupt vector is loaded.

Function
REQ-017 States: BOOT, RUN, INT_PC, INT_FLAGS, INT_JUMP.
REQ-018 BOOT: fetch_en=0, pc=RESET_ADDR; next state is always RUN.
REQ-019 RUN next-pc priority: ret_valid -> ret_pc; else branch_taken -> branch_target; else stall -> hold; else two_word -> pc+2; else pc+1.
REQ-020 RUN: fetch_en = !stall; flush=1 in any cycle that a ret or branch redirect is taken.
REQ-021 Pc arithmetic is modulo 2^PC_WIDTH, so all-ones+1 wraps to 0 and all-ones+2 wraps to 1.
REQ-022 A rising edge of int_req sets sticky int_pending; int_pending clears only on int_ack.
REQ-023 Interrupt acceptance in RUN occurs when int_pending=1, stall=0, ret_valid=0 and branch_taken=0.
REQ-024 Acceptance cycle: saved_pc <= pc, flush=1, fetch_en=0, pc held, next state INT_PC.
REQ-025 INT_PC: push_pc=1 and push_data=saved_pc for 1 cycle, then INT_FLAGS.
REQ-026 INT_FLAGS: push_flags=1 for 1 cycle, then INT_JUMP.
REQ-027 INT_JUMP: pc <= INT_ADDR, int_ack=1, then RUN.
REQ-028 Interrupt entry latency is 4 cycles from acceptance to the first fetch of INT_ADDR.
REQ-029 fetch_en=0 in all INT_* states.
REQ-030 stall=1 in any INT_* state freezes the state and keeps the current push strobe asserted.
REQ-031 Redirect inputs are ignored in INT_* states.
REQ-032 A new int_req edge during INT_* sets int_pending if it is already clear after ack; it is served only after at least one RUN fetch.
REQ-033 A redirect and a pending interrupt in the same cycle: redirect first; the interrupt is accepted later with saved_pc = target.
REQ-034 All outputs are registered or decoded from registered state only; no combinational path from int_req to any output.

Reset
REQ-035 rst_n=0 asynchronously forces state=BOOT, pc=RESET_ADDR, saved_pc=0 and int_pending=0.
REQ-036 rst_n=0 asynchronously forces fetch_en=0, flush=0, push_pc=0, push_flags=0, push_data=0 and int_ack=0.
REQ-037 Reset asserted mid interrupt sequence aborts it; no push strobe or int_ack follows release.
REQ-038 int_req already high at reset release is not an edge and does not set int_pending.

Structure
REQ-039 The state encoding, PC_WIDTH default, RESET_ADDR and INT_ADDR belong in the shared processor package.
REQ-040 The block is one module; an edge-detect sub-module int_edge_latch (sticky pending flag with clear) is natural.

Verification
REQ-041 Reset release, all inputs 0 -> BOOT 1 cycle, then pc = 0, 1, 2, 3 with fetch_en=1.
REQ-042 two_word=1 at pc=5 -> next pc=7; pc=0xFFFFFFFF with two_word=1 -> next pc=1.
REQ-043 branch_taken with target 0x40 and simultaneous ret_valid with ret_pc 0x80 -> pc=0x80, flush=1 for 1 cycle.
REQ-044 int_req edge at pc=0x10 -> flush, then push_pc with push_data=0x10, then push_flags, then int_ack with pc=0x20, then fetch at 0x20.
REQ-045 stall=1 for 3 cycles during INT_PC -> push_pc held for 4 cycles, push_data stable, total entry latency 7 cycles.
REQ-046 rst_n pulsed low in INT_FLAGS -> outputs 0 immediately; after release, no int_ack and pc restarts at 0.
